// File: rtl/tl45_fetch_pkg.sv
// Shared encodings and payload types for the TL45 instruction-fetch stage.
package tl45_fetch_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned WADDR_W = 30;
    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] S_REQ   = 3'd1;
    localparam logic [STATE_W-1:0] S_WAIT  = 3'd2;
    localparam logic [STATE_W-1:0] S_HOLD  = 3'd3;
    localparam logic [STATE_W-1:0] S_DRAIN = 3'd4;
    localparam logic [STATE_W-1:0] S_ERR   = 3'd5;

    localparam logic [XLEN-1:0] NOP_INST = 32'h0;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_buf_t;

endpackage

// File: rtl/tl45_fetch.sv
// TL45 fetch stage: owns the PC, one outstanding Wishbone read, feeds decode.
// Define TL45_FETCH_BUSERR_EN to trap bus errors in S_ERR and expose o_fetch_err.
module tl45_fetch
    import tl45_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_pipe_stall,
    input  logic               i_pipe_flush,
    input  logic [XLEN-1:0]    i_new_pc,
    output logic               o_wb_cyc,
    output logic               o_wb_stb,
    output logic [WADDR_W-1:0] o_wb_addr,
    input  logic               i_wb_stall,
    input  logic               i_wb_ack,
    input  logic               i_wb_err,
    input  logic [XLEN-1:0]    i_wb_data,
`ifdef TL45_FETCH_BUSERR_EN
    output logic               o_fetch_err,
`endif
    output logic [XLEN-1:0]    o_buf_pc,
    output logic [XLEN-1:0]    o_buf_inst
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [XLEN-1:0]    hold_q, hold_d;
    fetch_buf_t         buf_q, buf_d;
    logic               cyc_q, cyc_d;
    logic               stb_q, stb_d;
    logic [WADDR_W-1:0] addr_q, addr_d;
    logic               err_q, err_d;

    logic               done;
    logic               ack;
    logic               bus_err;
    logic               outstanding;
    logic [XLEN-1:0]    rdata;

    // Next-state, PC, hold and presentation logic; flush overrides everything.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        hold_d      = hold_q;
        buf_d       = i_pipe_stall ? buf_q : '0;
        outstanding = 1'b0;
        done        = i_wb_ack | i_wb_err;
`ifdef TL45_FETCH_BUSERR_EN
        ack         = i_wb_ack;
        bus_err     = i_wb_err;
        rdata       = i_wb_data;
`else
        ack         = done;
        bus_err     = 1'b0;
        rdata       = i_wb_err ? NOP_INST : i_wb_data;
`endif

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                outstanding = !i_wb_stall;
                if (!i_wb_stall) state_d = S_WAIT;
            end
            S_WAIT: begin
                outstanding = !done;
                if (bus_err) begin
                    state_d = S_ERR;
                end else if (ack) begin
                    if (i_pipe_stall) begin
                        hold_d  = rdata;
                        state_d = S_HOLD;
                    end else begin
                        buf_d.pc   = pc_q;
                        buf_d.inst = rdata;
                        pc_d       = pc_q + XLEN'(4);
                        state_d    = S_REQ;
                    end
                end
            end
            S_HOLD: begin
                if (!i_pipe_stall) begin
                    buf_d.pc   = pc_q;
                    buf_d.inst = hold_q;
                    pc_d       = pc_q + XLEN'(4);
                    state_d    = S_REQ;
                end
            end
            S_DRAIN: begin
                outstanding = !done;
                if (done) state_d = S_REQ;
            end
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase

        // A read still in flight must be drained before the redirect fetch.
        if (i_pipe_flush) begin
            buf_d   = '0;
            hold_d  = '0;
            pc_d    = i_new_pc & ~XLEN'(3);
            state_d = outstanding ? S_DRAIN : S_REQ;
        end

        cyc_d  = (state_d == S_REQ) || (state_d == S_WAIT) || (state_d == S_DRAIN);
        stb_d  = (state_d == S_REQ);
        addr_d = pc_d[XLEN-1:2];
        err_d  = (state_d == S_ERR);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            hold_q  <= '0;
            buf_q   <= '0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            addr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
            buf_q   <= buf_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    assign o_wb_cyc   = cyc_q;
    assign o_wb_stb   = stb_q;
    assign o_wb_addr  = addr_q;
    assign o_buf_pc   = buf_q.pc;
    assign o_buf_inst = buf_q.inst;
`ifdef TL45_FETCH_BUSERR_EN
    assign o_fetch_err = err_q;
`else
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule
